// File: rtl/dac_serializer_pkg.sv
// Shared definitions for the DAC serializer: sample width and FSM state encoding.
// The sample width matches the wavetable stage's output word.
package dac_serializer_pkg;

  localparam int SAMPLE_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_e;

endpackage

// File: rtl/dac_bit_timer.sv
// SCLK prescaler for the DAC serializer: one serial bit lasts 2*SCLK_DIV clk
// cycles, with SCLK high for the first half and low for the second.
module dac_bit_timer #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic stop,
  output logic sclk,
  output logic half_tick,
  output logic bit_end
);

  localparam int PERIOD = 2 * SCLK_DIV;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  // Strobes mark the last clk of a half-bit / of a whole bit.
  assign bit_end   = active && (cnt == CW'(PERIOD - 1));
  assign half_tick = active && ((cnt == CW'(SCLK_DIV - 1)) || (cnt == CW'(PERIOD - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (start) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (active && !stop) begin
      if (bit_end) begin
        cnt  <= '0;
        sclk <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(SCLK_DIV - 1)) begin
          sclk <= 1'b0;
        end
      end
    end else begin
      cnt  <= '0;
      sclk <= 1'b0;
    end
  end

endmodule

// File: rtl/dac_serializer.sv
// Serializes wavetable samples to an SPI-style audio DAC: a control byte then the
// sample, MSB first, framed by active-low sync, with a one-deep pending buffer.
module dac_serializer
  import dac_serializer_pkg::*;
#(
  parameter int                    DATAWIDTH  = SAMPLE_WIDTH,
  parameter int                    CTRL_WIDTH = 8,
  parameter logic [CTRL_WIDTH-1:0] CTRL_WORD  = 8'h10,
  parameter int                    SCLK_DIV   = 2,
  parameter int                    GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  // din is captured on every clk where din_valid is high; there is no
  // backpressure, so a sample that cannot be stored overwrites the pending one.
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 din_valid,
  input  logic                 clr_overrun,
  output logic                 busy,
  output logic                 overrun,
  output logic                 frame_done,
  output logic                 dac_sclk,
  output logic                 dac_sync_n,
  output logic                 dac_sdi
);

  localparam int FRAME_BITS = CTRL_WIDTH + DATAWIDTH;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int GW         = $clog2(GAP_CYCLES + 1);

  dac_state_e                state;
  logic [FRAME_BITS-2:0]     shreg;
  logic [BW-1:0]             bit_cnt;
  logic [GW-1:0]             gap_cnt;
  logic [DATAWIDTH-1:0]      pend_data;
  logic                      pend_full;

  logic                      half_tick;
  logic                      bit_end;
  logic                      timer_active;
  logic                      gap_last;
  logic                      frame_last;
  logic                      start_frame;
  logic                      take_din;
  logic                      pend_wr;
  logic                      overrun_set;
  logic [FRAME_BITS-1:0]     next_frame;

  always_comb begin
    gap_last     = 1'b0;
    frame_last   = 1'b0;
    start_frame  = 1'b0;
    take_din     = 1'b0;
    pend_wr      = 1'b0;
    overrun_set  = 1'b0;
    timer_active = 1'b0;
    next_frame   = '0;

    timer_active = (state == ST_SHIFT);
    gap_last     = (state == ST_GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));
    frame_last   = timer_active && bit_end && (bit_cnt == BW'(FRAME_BITS - 1));
    start_frame  = enable && (((state == ST_IDLE) && (pend_full || din_valid)) ||
                              (gap_last && pend_full));
    take_din     = enable && din_valid;
    // A pending sample always goes first; a same-cycle strobe then refills pending.
    pend_wr      = take_din && !(start_frame && !pend_full);
    overrun_set  = take_din && pend_full && !start_frame;
    next_frame   = {CTRL_WORD, (pend_full ? pend_data : din)};
  end

  dac_bit_timer #(
    .SCLK_DIV (SCLK_DIV)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_frame),
    .active    (timer_active),
    .stop      (frame_last),
    .sclk      (dac_sclk),
    .half_tick (half_tick),
    .bit_end   (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      pend_data  <= '0;
      pend_full  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_done <= 1'b0;
      dac_sync_n <= 1'b1;
      dac_sdi    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (!enable) begin
        pend_full <= 1'b0;
      end else if (pend_wr) begin
        pend_data <= din;
        pend_full <= 1'b1;
      end else if (start_frame) begin
        pend_full <= 1'b0;
      end

      // A set event in the same cycle as a clear keeps the flag high.
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_frame) begin
            state      <= ST_SHIFT;
            shreg      <= next_frame[FRAME_BITS-2:0];
            dac_sdi    <= next_frame[FRAME_BITS-1];
            dac_sync_n <= 1'b0;
            bit_cnt    <= '0;
            busy       <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (frame_last) begin
            state      <= ST_GAP;
            dac_sync_n <= 1'b1;
            dac_sdi    <= 1'b0;
            frame_done <= 1'b1;
            gap_cnt    <= '0;
          end else if (bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
            dac_sdi <= shreg[FRAME_BITS-2];
            shreg   <= {shreg[FRAME_BITS-3:0], 1'b0};
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_last) begin
            if (start_frame) begin
              state      <= ST_SHIFT;
              shreg      <= next_frame[FRAME_BITS-2:0];
              dac_sdi    <= next_frame[FRAME_BITS-1];
              dac_sync_n <= 1'b0;
              bit_cnt    <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          dac_sync_n <= 1'b1;
          dac_sdi    <= 1'b0;
        end
      endcase
    end
  end

  // Every bit boundary is also the end of a half-bit.
  a_bit_end_on_half : assert property (@(posedge clk) disable iff (!rst_n)
    bit_end |-> half_tick);

endmodule

// File: doc/dac_serializer.md
Name: dac_serializer

Overview:
Downstream stage of the wavetable oscillator: accepts each 16-bit output sample (the wavetable's dout) with a one-cycle valid strobe and shifts it to an external SPI-style audio DAC. Each frame is a fixed control byte followed by the sample, MSB first, framed by an active-low sync. A one-deep pending buffer absorbs a sample that arrives mid-frame; overflow of that buffer is flagged.

Parameters:
DATAWIDTH, 16, sample width (matches the shared `DATAWIDTH define)
CTRL_WIDTH, 8, control-prefix bits per frame
CTRL_WORD, 8'h10, control prefix sent before every sample
SCLK_DIV, 2, clk cycles per SCLK half-period (>=1)
GAP_CYCLES, 4, minimum clk cycles sync_n stays high between frames (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new frames to start
din  in  DATAWIDTH  sample from the wavetable stage
din_valid  in  1  one-cycle strobe: din is valid
clr_overrun  in  1  clears the overrun flag
busy  out  1  high while in SHIFT or GAP
overrun  out  1  sticky: a pending sample was overwritten
frame_done  out  1  one-cycle pulse when sync_n rises
dac_sclk  out  1  DAC serial clock; idles low
dac_sync_n  out  1  DAC frame sync, active low
dac_sdi  out  1  DAC serial data

Behaviour:
- Reset: async on rst_n low; FSM=IDLE; pending empty; busy=0, overrun=0, frame_done=0, dac_sclk=0, dac_sync_n=1, dac_sdi=0. Reset mid-frame aborts immediately; no partial-frame recovery.
- FRAME_BITS = CTRL_WIDTH+DATAWIDTH (24 by default). Shift register {CTRL_WORD, sample}.
- States: IDLE, SHIFT, GAP.
- IDLE: din_valid (or pending full) with enable=1 -> SHIFT. Cycle after the strobe: dac_sync_n=0, dac_sdi=frame MSB, busy=1. Latency = 1 clk. A pending sample takes priority over a same-cycle din_valid; the new din goes into pending.
- SHIFT: each bit lasts 2*SCLK_DIV clks. dac_sdi changes only at bit start. dac_sclk is high for the first SCLK_DIV clks and low for the second, so the DAC samples on the falling edge mid-bit. After FRAME_BITS bits: dac_sync_n=1, dac_sclk=0, dac_sdi=0, frame_done=1 for one clk -> GAP. sync_n is low for exactly FRAME_BITS*2*SCLK_DIV clks (96 by default).
- GAP: sync_n high for GAP_CYCLES clks. Then, if pending is full and enable=1, go directly to SHIFT (sync_n falls on the next clk); otherwise go to IDLE.
- din_valid while busy: sample goes to pending. If pending is already full, overwrite it (newest wins) and set overrun=1.
- overrun: cleared by clr_overrun. A set event in the same cycle as clr_overrun wins (overrun stays 1).
- enable=0: the current frame and gap complete normally. No new frame starts. Pending is cleared and din_valid is ignored while enable=0.
- The sample is latched at the strobe; later changes on din do not affect a frame in progress.

Decomposition:
- Shared defines header: `DATAWIDTH plus FSM state encodings (IDLE/SHIFT/GAP localparams).
- One sub-module, dac_bit_timer: SCLK_DIV prescaler producing sclk level, a half_tick, and a bit_end strobe.
- Shift register, bit counter, pending buffer and FSM stay in dac_serializer.

Test Plan:
- Reset then idle, no strobes for 50 clks -> dac_sync_n=1, dac_sclk=0, dac_sdi=0, busy=0, frame_done never pulses.
- Single frame: din=16'hA5C3 with one-cycle din_valid -> sync_n falls 1 clk later and stays low for 96 clks. Bits captured on SCLK falling edges = 24'h10A5C3. frame_done pulses once; busy drops after 4 more clks.
- Back-to-back: second strobe din=16'h0001 at clk 20 of frame 1 -> frame 2 starts exactly 4 clks after sync_n rises and carries 24'h100001. overrun stays 0.
- Overrun: three strobes (16'h1111, 16'h2222, 16'h3333) in one frame window -> frame 2 carries 24'h103333 and overrun=1. clr_overrun pulse -> overrun=0. clr_overrun in the same clk as a new overwrite -> overrun stays 1.
- Enable drop: deassert enable at mid-frame with a sample pending -> the current frame completes (96 clks). No further frame starts, pending is discarded, and busy returns to 0 after the gap.
- Reset mid-frame: assert rst_n low at bit 10 -> outputs go to idle values asynchronously. After release, a new strobe of 16'hFFFF produces a clean 24'h10FFFF frame.
